expr_sig_compactor: RTL and testbench
=====================================

# expr_sig_compactor

Downstream response compactor for the vloghammer expression modules. It accepts the 90-bit concatenated result bus `y` over a valid/ready handshake, one vector per handshake, and folds each vector into a 32-bit MISR signature. After a programmed number of vectors it reports a single signature, so regression can compare one word per run instead of every vector.

## Interface

Parameters:
- `Y_W`, 90 — width of the expression result bus.
- `SIG_W`, 32 — signature width; fixed at 32 for this block.
- `CNT_W`, 16 — width of the vector counter and of `num_vec`.
- `POLY`, 32'h04C11DB7 — MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF — signature value loaded on `start`.

Ports:
- `clk` input 1 — the single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — one-cycle pulse that begins a run; sampled in IDLE and DONE only.
- `num_vec` input CNT_W — number of vectors to compact; sampled on `start`.
- `y_valid` input 1 — a result vector is present on `y`.
- `y` input Y_W — result bus `{y0..y17}` from the expression stage.
- `y_ready` output 1 — compactor accepts `y` this cycle.
- `busy` output 1 — high in RUN.
- `done` output 1 — high in DONE; held until the next `start` or reset.
- `signature` output SIG_W — current MISR value.
- `vec_count` output CNT_W — number of vectors accepted in the current run.

## Operation

- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE and clears `signature`, `vec_count`, `done` and `busy` to 0.
- A **handshake** occurs on any cycle where `y_valid && y_ready`.
- **Fold:** `f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}`.
- **MISR step:** `sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ f`.
- **IDLE:**
  - `y_ready` = 0.
  - On `start`: load `signature` = SEED, `vec_count` = 0 and latch `num_vec`.
  - If `num_vec` == 0, go to DONE; otherwise go to RUN.
- **RUN:**
  - `y_ready` = 1 and `busy` = 1.
  - On each handshake: `signature` ← `sig_next` and `vec_count` ← `vec_count` + 1.
  - The handshake that brings `vec_count` to the latched `num_vec` moves the FSM to DONE.
  - Cycles with `y_valid` = 0 change nothing.
  - `start` is ignored in RUN.
- **DONE:**
  - `done` = 1, `y_ready` = 0.
  - `signature` and `vec_count` are frozen.
  - `start` restarts exactly as from IDLE (reload SEED, clear count), and `done` drops.
- **Widths:** `vec_count` never wraps, because a run terminates at `num_vec` ≤ 2^CNT_W − 1.
- **Input stability:** `y` and `y_valid` are allowed to change on any cycle; a vector presented while `y_ready` = 0 is not consumed, and the producer must hold it.
- **Mid-run reset:** `rst_n` asserted mid-run aborts immediately to IDLE with all outputs 0. No partial signature is retained.

## Timing

- `y_ready`, `busy` and `done` are decoded from the registered FSM state only. There is no combinational path from `y_valid` or `start` to any output.
- `start` in cycle N:
  - `busy` = 1 and `y_ready` = 1 in cycle N+1, or `done` = 1 in N+1 when `num_vec` = 0.
  - `signature` = SEED is visible in N+1.
- A handshake in cycle N updates `signature` and `vec_count` as seen in cycle N+1.
- The final handshake in cycle N gives:
  - `done` = 1 and `y_ready` = 0 in N+1;
  - the final signature valid from N+1 onward.
- Throughput is one vector per cycle with `y_valid` held high. A run of K vectors takes K+1 cycles from `start` to `done`.
- `start` coincident with reset deassertion is ignored, because reset dominates.

## Test plan

- Reset, then `start` with `num_vec` = 0 → `done` = 1 in the next cycle, `signature` = 32'hFFFFFFFF, `vec_count` = 0, and `y_ready` never high.
- `num_vec` = 1, `y` = 0 → after one handshake `signature` = 32'hFB3EE249 and `vec_count` = 1. Then `num_vec` = 1, `y` = 90'h1 → `signature` = 32'hFB3EE248.
- `num_vec` = 2, `y` = 0 on both vectors, with `y_valid` low for 3 cycles between them → `signature` = 32'hF2BCD925 and `vec_count` = 2. Idle cycles must not change the count or the signature.
- `num_vec` = 3 with a `start` pulse after the first handshake → the pulse is ignored; the run completes after exactly 3 handshakes. A `start` in DONE then restarts the run, giving `signature` = SEED and `done` = 0.
- Reset asserted after 2 of 5 handshakes → all outputs are 0 asynchronously (before the next edge). A new `start` after release runs cleanly from SEED.
- Random `y` and `y_valid` over 1000 vectors, compared against a bench reference model of fold+MISR → the final signature matches, and `vec_count` = 1000.

Source files
------------

// File: rtl/expr_sig_compactor.sv
// Folds 90-bit expression results into a 32-bit MISR signature over num_vec handshakes.
// Latency: one cycle per accepted vector; y_ready only in RUN, so producers hold y otherwise.
module expr_sig_compactor #(
  parameter int          Y_W   = 90,
  parameter int          SIG_W = 32,
  parameter int          CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             y_valid,
  input  logic [Y_W-1:0]   y,
  output logic             y_ready,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;

  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;

  // Top 26 bits of y are zero-extended so all 90 bits reach the signature.
  assign fold     = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vec;
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (y_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  // Handshake outputs decode the registered state only; no input-to-output paths.
  assign y_ready   = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_expr_sig_compactor.sv
// Directed bench for expr_sig_compactor with a fold+MISR reference for the random run.
module tb_expr_sig_compactor;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic        y_valid;
  logic [89:0] y;
  logic        y_ready;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [15:0] vec_count;

  int n_chk;
  int n_err;

  expr_sig_compactor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .vec_count (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] v);
    logic [31:0] f;
    f = v[31:0] ^ v[63:32] ^ {6'b0, v[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  initial begin
    logic [31:0] model_sig;
    int          model_cnt;
    logic [95:0] rnd;

    n_chk   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    num_vec = '0;
    y_valid = 1'b0;
    y       = '0;
    #1;
    chk("rst_sig",   signature, 32'h0);
    chk("rst_cnt",   {16'h0, vec_count}, 32'h0);
    chk("rst_done",  {31'h0, done}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, y_ready}, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // num_vec = 0 goes straight to DONE
    start = 1'b1; num_vec = 16'd0;
    step();
    start = 1'b0;
    chk("nv0_done",  {31'h0, done}, 32'h1);
    chk("nv0_sig",   signature, SEED);
    chk("nv0_cnt",   {16'h0, vec_count}, 32'h0);
    chk("nv0_ready", {31'h0, y_ready}, 32'h0);

    // single zero vector
    start = 1'b1; num_vec = 16'd1;
    step();
    start = 1'b0;
    chk("nv1_busy",  {31'h0, busy}, 32'h1);
    chk("nv1_ready", {31'h0, y_ready}, 32'h1);
    chk("nv1_seed",  signature, SEED);
    y_valid = 1'b1; y = '0;
    step();
    y_valid = 1'b0;
    chk("nv1_done",  {31'h0, done}, 32'h1);
    chk("nv1_rdy0",  {31'h0, y_ready}, 32'h0);
    chk("nv1_sig",   signature, 32'hFB3EE249);
    chk("nv1_cnt",   {16'h0, vec_count}, 32'h1);

    // single vector y = 1
    start = 1'b1; num_vec = 16'd1;
    step();
    start = 1'b0;
    y_valid = 1'b1; y = 90'h1;
    step();
    y_valid = 1'b0; y = '0;
    chk("y1_sig", signature, 32'hFB3EE248);

    // two vectors with idle gap
    start = 1'b1; num_vec = 16'd2;
    step();
    start = 1'b0;
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
    chk("gap_cnt1", {16'h0, vec_count}, 32'h1);
    step(); step(); step();
    chk("gap_cnt_hold", {16'h0, vec_count}, 32'h1);
    chk("gap_sig_hold", signature, 32'hFB3EE249);
    chk("gap_busy",     {31'h0, busy}, 32'h1);
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
    chk("gap_sig",  signature, 32'hF2BCD925);
    chk("gap_cnt",  {16'h0, vec_count}, 32'h2);
    chk("gap_done", {31'h0, done}, 32'h1);

    // start during RUN is ignored
    start = 1'b1; num_vec = 16'd3;
    step();
    start = 1'b0;
    y_valid = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_cnt",  {16'h0, vec_count}, 32'h2);
    chk("ign_busy", {31'h0, busy}, 32'h1);
    chk("ign_done", {31'h0, done}, 32'h0);
    step();
    y_valid = 1'b0;
    chk("ign_done3", {31'h0, done}, 32'h1);
    chk("ign_cnt3",  {16'h0, vec_count}, 32'h3);
    chk("ign_sig3",  signature, 32'hE1B8AFFD);
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
    chk("frz_cnt", {16'h0, vec_count}, 32'h3);
    chk("frz_sig", signature, 32'hE1B8AFFD);

    // restart from DONE, then reset mid-run
    start = 1'b1; num_vec = 16'd5;
    step();
    start = 1'b0;
    chk("rs_sig",  signature, SEED);
    chk("rs_done", {31'h0, done}, 32'h0);
    chk("rs_busy", {31'h0, busy}, 32'h1);
    y_valid = 1'b1;
    step();
    step();
    y_valid = 1'b0;
    chk("mid_cnt", {16'h0, vec_count}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sig",   signature, 32'h0);
    chk("arst_cnt",   {16'h0, vec_count}, 32'h0);
    chk("arst_busy",  {31'h0, busy}, 32'h0);
    chk("arst_ready", {31'h0, y_ready}, 32'h0);
    chk("arst_done",  {31'h0, done}, 32'h0);
    step();
    rst_n = 1'b1;
    start = 1'b1; num_vec = 16'd1;
    step();
    start = 1'b0;
    chk("post_seed", signature, SEED);
    y_valid = 1'b1; y = '0;
    step();
    y_valid = 1'b0;
    chk("post_sig", signature, 32'hFB3EE249);

    // 1000 random vectors with random valid gaps
    start = 1'b1; num_vec = 16'd1000;
    step();
    start = 1'b0;
    model_sig = SEED;
    model_cnt = 0;
    for (int c = 0; c < 5000 && model_cnt < 1000; c++) begin
      rnd     = {$urandom, $urandom, $urandom};
      y       = rnd[89:0];
      y_valid = ($urandom_range(0, 3) != 0);
      if (y_valid && y_ready) begin
        model_sig = ref_misr(model_sig, y);
        model_cnt++;
      end
      step();
    end
    y_valid = 1'b0;
    chk("rnd_done", {31'h0, done}, 32'h1);
    chk("rnd_cnt",  {16'h0, vec_count}, 32'd1000);
    chk("rnd_sig",  signature, model_sig);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
